// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: NOP filler word, fetch exception
// causes and the buffered fetch entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR              = 32'h00000013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch FIFO between imem capture and decode; flush empties it
// in one cycle. Payload storage is not reset, only pointers and count.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, RUN/HALT control and handoff to decode.
// Optional macro IFETCH_MISALIGN_CHECK_EN raises misaligned-fetch exceptions.
module ifetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_exc_en,
  output logic [3:0]  id_exc_code,
  output logic [63:0] id_exc_val
);

  fetch_state_e state, state_next;
  logic [63:0]  fpc, fpc_next;
  logic [1:0]   count;
  logic         push, pop;
  fetch_entry_t fetch_entry, head;

  always_comb begin
    fetch_entry = '{pc: fpc, instr: imem_instr, exc_en: imem_exc_en,
                    exc_code: imem_exc_code, exc_val: imem_exc_val};
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (fpc[1:0] != 2'b00) begin
      fetch_entry = '{pc: fpc, instr: NOP_INSTR, exc_en: 1'b1,
                      exc_code: EXC_INSTR_MISALIGNED, exc_val: fpc};
    end
`endif
  end

  // A redirect hides the head so nothing is consumed from the wrong path.
  assign id_valid = (count != 2'd0) && !redirect_en;
  assign pop      = id_valid && id_ready;
  assign push     = (state == RUN) && !redirect_en && ((count != 2'd2) || pop);

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    if (redirect_en) begin
      state_next = RUN;
      fpc_next   = redirect_pc;
    end else if (push) begin
      if (fetch_entry.exc_en) state_next = HALT;
      else                    fpc_next   = fpc + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fpc   <= RESET_PC;
    end else begin
      state <= state_next;
      fpc   <= fpc_next;
    end
  end

  fetch_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_en),
    .wr_entry (fetch_entry),
    .count    (count),
    .head     (head)
  );

  assign imem_addr   = rst ? RESET_PC : fpc;
  assign id_pc       = id_valid ? head.pc       : 64'd0;
  assign id_instr    = id_valid ? head.instr    : NOP_INSTR;
  assign id_exc_en   = id_valid ? head.exc_en   : 1'b0;
  assign id_exc_code = id_valid ? head.exc_code : 4'd0;
  assign id_exc_val  = id_valid ? head.exc_val  : 64'd0;

endmodule

// File: tb/tb_ifetch.sv
// Randomized scoreboard bench for ifetch against a queue-based reference model.
module tb_ifetch;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } exp_t;

  logic        clk, rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;

  int checks = 0;
  int errors = 0;

  bit          fault_on;
  bit          chk_en;
  exp_t        exp_q[$];
  logic [63:0] m_fpc;
  bit          m_halt;
  int          m_cnt;
  bit          exp_valid, exp_empty;
  logic [63:0] exp_addr;

  ifetch #(.RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code),
    .imem_exc_val(imem_exc_val), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_exc_en(id_exc_en),
    .id_exc_code(id_exc_code), .id_exc_val(id_exc_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  function automatic logic mem_fault(input logic [63:0] a, input bit on);
    return on && ((a[7:2] == 6'h15) || (a == 64'h2000));
  endfunction

  always_comb begin
    imem_instr    = mem_word(imem_addr);
    imem_exc_en   = mem_fault(imem_addr, fault_on);
    imem_exc_code = 4'd1;
    imem_exc_val  = imem_addr;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the fetch rules to the same inputs.
  task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc, input bit rs);
    exp_t e;
    bit p, q, mis;
    id_ready = rdy; redirect_en = rd; redirect_pc = rpc; rst = rs;
    exp_valid = (m_cnt > 0) && !rd;
    exp_empty = (m_cnt == 0);
    exp_addr  = rs ? 64'h0 : m_fpc;
    if (rs) begin
      exp_q.delete(); m_cnt = 0; m_fpc = 64'h0; m_halt = 0;
    end else if (rd) begin
      exp_q.delete(); m_cnt = 0; m_fpc = rpc; m_halt = 0;
    end else begin
      p = (m_cnt > 0) && rdy;
      q = !m_halt && ((m_cnt < 2) || p);
      if (q) begin
        mis = 0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        mis = (m_fpc[1:0] != 2'b00);
`endif
        e.pc = m_fpc;
        if (mis) begin
          e.instr = 32'h00000013; e.exc_en = 1'b1; e.code = 4'd0; e.val = m_fpc;
        end else begin
          e.instr = mem_word(m_fpc); e.exc_en = mem_fault(m_fpc, fault_on);
          e.code = 4'd1; e.val = m_fpc;
        end
        exp_q.push_back(e);
        if (e.exc_en) m_halt = 1;
        else          m_fpc = m_fpc + 64'd4;
      end
      m_cnt = m_cnt + int'(q) - int'(p);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      check("id_valid", {63'd0, id_valid}, {63'd0, exp_valid});
      check("imem_addr", imem_addr, exp_addr);
      if (exp_empty) begin
        check("empty_pc", id_pc, 64'd0);
        check("empty_instr", {32'd0, id_instr}, 64'h13);
        check("empty_exc", {59'd0, id_exc_en, id_exc_code}, 64'd0);
        check("empty_val", id_exc_val, 64'd0);
      end
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", id_pc, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e.pc);
          check("id_instr", {32'd0, id_instr}, {32'd0, e.instr});
          check("id_exc_en", {63'd0, id_exc_en}, {63'd0, e.exc_en});
          check("id_exc_code", {60'd0, id_exc_code}, {60'd0, e.code});
          check("id_exc_val", id_exc_val, e.val);
        end
      end
    end
  end

  initial begin
    logic [31:0] rv;
    logic [63:0] rpc;
    bit          rdy, rd, rs;
    rst = 1'b1; id_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 64'd0;
    fault_on = 0; chk_en = 0; m_cnt = 0; m_fpc = 64'd0; m_halt = 0;
    exp_valid = 0; exp_empty = 1; exp_addr = 64'd0;
    step(0, 0, 64'd0, 1);
    step(0, 0, 64'd0, 1);
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_pc", id_pc, 64'd0);
    check("rst_instr", {32'd0, id_instr}, 64'h13);
    check("rst_exc", {59'd0, id_exc_en, id_exc_code}, 64'd0);
    check("rst_val", id_exc_val, 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    chk_en = 1;
    step(1, 0, 64'd0, 1);

    repeat (6) step(1, 0, 64'd0, 0);
    step(0, 0, 64'd0, 1);
    repeat (4) step(0, 0, 64'd0, 0);
    check("stall_addr", imem_addr, 64'h8);
    repeat (6) step(1, 0, 64'd0, 0);

    fault_on = 1;
    step(1, 1, 64'h2000, 0);
    repeat (3) step(0, 0, 64'd0, 0);
    check("halt_addr", imem_addr, 64'h2000);
    repeat (4) step(1, 0, 64'd0, 0);
    check("halt_addr_drained", imem_addr, 64'h2000);

    step(0, 1, 64'h100, 0);
    repeat (3) step(0, 0, 64'd0, 0);
    step(1, 1, 64'h100, 0);
    check("flush_fpc", imem_addr, 64'h100);
    repeat (4) step(1, 0, 64'd0, 0);

    step(1, 1, 64'h102, 0);
    repeat (4) step(1, 0, 64'd0, 0);
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    repeat (4) step(1, 0, 64'd0, 0);

    for (int i = 0; i < 3000; i++) begin
      rv  = $urandom;
      rpc = {52'd0, rv[11:0]};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      if (rs) begin rdy = 0; rd = 0; end
      step(rdy, rd, rpc, rs);
    end
    step(0, 0, 64'd0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
